// File: rtl/adc_sample_packer.sv
// ADC capture front-end: decimates, packs samples plus two flag bits
// into FIFO words, stops after a programmed count and flushes partial words.
module adc_sample_packer #(
    parameter int SAMPLE_WIDTH     = 10,
    parameter int SAMPLES_PER_WORD = 3,
    parameter int WORD_WIDTH       = 32,
    parameter int CNT_WIDTH        = 32,
    parameter int DECIM_WIDTH      = 16
) (
    input  logic                    adc_sampleclk,
    input  logic                    ddr_usrreset,
    input  logic [SAMPLE_WIDTH-1:0] adc_datain,
    input  logic                    adc_or,
    input  logic                    adc_trig_status,
    input  logic                    capture_go,
    input  logic [DECIM_WIDTH-1:0]  decimate,
    input  logic [CNT_WIDTH-1:0]    max_samples,
    output logic [WORD_WIDTH-1:0]   fifo_din,
    output logic                    fifo_wr_en,
    input  logic                    fifo_full,
    output logic                    capture_stop,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    samples_captured,
    output logic                    overflow
);
    localparam int SLOT_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
    localparam int DATA_W = SAMPLE_WIDTH * SAMPLES_PER_WORD;

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

    state_t                 state;
    logic [DECIM_WIDTH-1:0] decim_q;
    logic [DECIM_WIDTH-1:0] dcnt;
    logic [CNT_WIDTH-1:0]   max_q;
    logic [SLOT_W-1:0]      slot;
    logic [DATA_W-1:0]      acc;
    logic                   or_acc;
    logic                   trig_acc;

    logic                   kept;
    logic                   word_full;
    logic                   last;
    logic                   emit;
    logic [DATA_W-1:0]      data_n;
    logic                   or_n;
    logic [CNT_WIDTH-1:0]   cnt_n;
    logic [WORD_WIDTH-1:0]  emit_word;

    function automatic logic [WORD_WIDTH-1:0] pack(
        input logic [DATA_W-1:0] d,
        input logic              o,
        input logic              t
    );
        logic [WORD_WIDTH-1:0] w;
        w               = '0;
        w[DATA_W-1:0]   = d;
        w[WORD_WIDTH-1] = o;
        w[WORD_WIDTH-2] = t;
        return w;
    endfunction

    always_comb begin
        kept   = (dcnt == '0);
        data_n = acc;
        for (int s = 0; s < SAMPLES_PER_WORD; s++) begin
            if (slot == SLOT_W'(s)) begin
                data_n[s*SAMPLE_WIDTH +: SAMPLE_WIDTH] = adc_datain;
            end
        end
        or_n      = or_acc | adc_or;
        cnt_n     = (&samples_captured) ? samples_captured : samples_captured + 1'b1;
        word_full = (slot == SLOT_W'(SAMPLES_PER_WORD - 1));
        last      = (cnt_n == max_q);
        emit      = (state == FLUSH) ||
                    ((state == CAPTURE) && capture_go && kept && word_full);
        emit_word = (state == FLUSH) ? pack(acc, or_acc, trig_acc)
                                     : pack(data_n, or_n, adc_trig_status);
    end

    always_ff @(posedge adc_sampleclk or posedge ddr_usrreset) begin
        if (ddr_usrreset) begin
            state            <= IDLE;
            fifo_din         <= '0;
            fifo_wr_en       <= 1'b0;
            capture_stop     <= 1'b0;
            busy             <= 1'b0;
            samples_captured <= '0;
            overflow         <= 1'b0;
            decim_q          <= '0;
            dcnt             <= '0;
            max_q            <= '0;
            slot             <= '0;
            acc              <= '0;
            or_acc           <= 1'b0;
            trig_acc         <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;
            if (emit) begin
                if (fifo_full) begin
                    overflow <= 1'b1;
                end else begin
                    fifo_din   <= emit_word;
                    fifo_wr_en <= 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (capture_go) begin
                        decim_q          <= decimate;
                        max_q            <= max_samples;
                        samples_captured <= '0;
                        overflow         <= 1'b0;
                        slot             <= '0;
                        dcnt             <= '0;
                        acc              <= '0;
                        or_acc           <= 1'b0;
                        trig_acc         <= 1'b0;
                        if (max_samples == '0) begin
                            state        <= DONE;
                            capture_stop <= 1'b1;
                        end else begin
                            state <= CAPTURE;
                            busy  <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (!capture_go) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (kept) begin
                        dcnt             <= decim_q;
                        samples_captured <= cnt_n;
                        if (word_full) begin
                            slot     <= '0;
                            acc      <= '0;
                            or_acc   <= 1'b0;
                            trig_acc <= 1'b0;
                        end else begin
                            slot     <= slot + 1'b1;
                            acc      <= data_n;
                            or_acc   <= or_n;
                            trig_acc <= adc_trig_status;
                        end
                        // a final sample that closes a word needs no flush cycle
                        if (last) begin
                            if (word_full) begin
                                state        <= DONE;
                                busy         <= 1'b0;
                                capture_stop <= 1'b1;
                            end else begin
                                state <= FLUSH;
                            end
                        end
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                FLUSH: begin
                    state        <= DONE;
                    busy         <= 1'b0;
                    capture_stop <= 1'b1;
                end
                DONE: begin
                    if (!capture_go) begin
                        state        <= IDLE;
                        capture_stop <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_sample_packer.sv
// Bench for adc_sample_packer: directed and random captures against
// a word-level reference model.
module tb_adc_sample_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  adc_datain;
    logic        adc_or;
    logic        adc_trig_status;
    logic        capture_go;
    logic [15:0] decimate;
    logic [31:0] max_samples;
    logic [31:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        capture_stop;
    logic        busy;
    logic [31:0] samples_captured;
    logic        overflow;

    adc_sample_packer dut (
        .adc_sampleclk   (clk),
        .ddr_usrreset    (rst),
        .adc_datain      (adc_datain),
        .adc_or          (adc_or),
        .adc_trig_status (adc_trig_status),
        .capture_go      (capture_go),
        .decimate        (decimate),
        .max_samples     (max_samples),
        .fifo_din        (fifo_din),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_full       (fifo_full),
        .capture_stop    (capture_stop),
        .busy            (busy),
        .samples_captured(samples_captured),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] wq[$];
    int          cq[$];
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            wq.push_back(fifo_din);
            cq.push_back(cyc);
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [9:0]  dat[256];
    logic        orv[256];
    logic        trg[256];
    logic        ful[256];
    logic [31:0] last_wr;

    task automatic fill(input int mode);
        for (int i = 0; i < 256; i++) begin
            dat[i] = (mode == 0) ? 10'(i + 1) : (mode == 1) ? 10'(i) : 10'($urandom);
            orv[i] = (mode == 2) ? ($urandom_range(0, 4) == 0) : 1'b0;
            trg[i] = (mode == 2) ? 1'($urandom) : 1'b0;
            ful[i] = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    endtask

    function automatic logic [31:0] wq_at(input int i);
        return (i < wq.size()) ? wq[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic run(input int d, input int mx, input string tag);
        logic [31:0] ew[$];
        int          ec[$];
        logic        eov;
        logic [31:0] w;
        int          j, e, base, t;
        eov = 1'b0;
        w   = '0;
        for (int k = 0; k < mx; k++) begin
            j = k * (d + 1);
            if (k % 3 == 0) w = '0;
            w[(k % 3) * 10 +: 10] = dat[j];
            w[31] = w[31] | orv[j];
            w[30] = trg[j];
            if (k % 3 == 2 || k == mx - 1) begin
                e = (k % 3 == 2) ? j : j + 1;
                if (ful[e]) eov = 1'b1;
                else begin
                    ew.push_back(w);
                    ec.push_back(e);
                end
            end
        end
        wq.delete();
        cq.delete();
        decimate    = 16'(d);
        max_samples = 32'(mx);
        fifo_full   = 1'b0;
        capture_go  = 1'b1;
        @(posedge clk);
        #1 base = cyc;
        chk({tag, "_busy_start"}, 64'(busy), 64'(mx != 0));
        t = (mx - 1) * (d + 1) + 3;
        for (int i = 0; i < t; i++) begin
            adc_datain      = dat[i];
            adc_or          = orv[i];
            adc_trig_status = trg[i];
            fifo_full       = ful[i];
            decimate        = 16'($urandom);
            max_samples     = $urandom;
            @(posedge clk);
            #1;
        end
        chk({tag, "_stop"}, 64'(capture_stop), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_count"}, 64'(samples_captured), 64'(mx));
        chk({tag, "_ovf"}, 64'(overflow), 64'(eov));
        chk({tag, "_nwr"}, 64'(wq.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size(); i++) begin
            chk({tag, "_word"}, 64'(wq_at(i)), 64'(ew[i]));
            chk({tag, "_when"}, 64'((i < cq.size()) ? cq[i] : -1), 64'(base + 1 + ec[i]));
        end
        if (ew.size() > 0) last_wr = ew[ew.size() - 1];
        chk({tag, "_din_hold"}, 64'(fifo_din), 64'(last_wr));
        capture_go = 1'b0;
        fifo_full  = 1'b0;
        @(posedge clk);
        #1 chk({tag, "_stop_clr"}, 64'(capture_stop), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        adc_datain = '0;
        adc_or = 1'b0;
        adc_trig_status = 1'b0;
        capture_go = 1'b0;
        decimate = '0;
        max_samples = '0;
        fifo_full = 1'b0;
        last_wr = '0;
        #12;
        chk("rst_din", 64'(fifo_din), 64'd0);
        chk("rst_wr", 64'(fifo_wr_en), 64'd0);
        chk("rst_flags", 64'({capture_stop, busy, overflow}), 64'd0);
        chk("rst_cnt", 64'(samples_captured), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        fill(0);
        run(0, 6, "ramp6");
        chk("ramp6_w0", 64'(wq_at(0)), 64'h0030_0801);
        chk("ramp6_w1", 64'(wq_at(1)), 64'h0060_1404);

        fill(0);
        run(0, 4, "ramp4");
        chk("ramp4_w0", 64'(wq_at(0)), 64'h0030_0801);
        chk("ramp4_flush", 64'(wq_at(1)), 64'h0000_0004);

        fill(1);
        run(2, 3, "decim2");
        chk("decim2_w0", 64'(wq_at(0)), 64'h0060_0C00);

        fill(0);
        orv[1] = 1'b1;
        trg[2] = 1'b1;
        run(0, 6, "flags");
        chk("flags_w0", 64'(wq_at(0) >> 30), 64'd3);
        chk("flags_w1", 64'(wq_at(1) >> 31), 64'd0);

        fill(0);
        ful[2] = 1'b1;
        run(0, 6, "full");
        chk("full_w", 64'(wq_at(0)), 64'h0060_1404);

        wq.delete();
        max_samples = '0;
        capture_go  = 1'b1;
        @(posedge clk);
        #1;
        chk("zero_stop", 64'(capture_stop), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_cnt", 64'(samples_captured), 64'd0);
        @(posedge clk);
        #1 chk("zero_nwr", 64'(wq.size()), 64'd0);
        capture_go = 1'b0;
        @(posedge clk);
        #1;

        fill(0);
        wq.delete();
        decimate    = '0;
        max_samples = 32'd6;
        capture_go  = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            #1 adc_datain = dat[i];
            @(posedge clk);
        end
        #1 capture_go = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_cnt", 64'(samples_captured), 64'd2);
        chk("abort_stop", 64'(capture_stop), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("abort_nwr", 64'(wq.size()), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        max_samples = 32'd10;
        capture_go  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            adc_datain = dat[i];
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_din", 64'(fifo_din), 64'd0);
        chk("arst_cnt", 64'(samples_captured), 64'd0);
        chk("arst_flags", 64'({fifo_wr_en, capture_stop, busy, overflow}), 64'd0);
        capture_go = 1'b0;
        last_wr = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 20; r++) begin
            fill(2);
            run($urandom_range(0, 3), $urandom_range(1, 40), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
